fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage: PC register, next-PC selection and a
// two-state fetch controller talking to a simple request/ready instruction memory.
//
// Parameters
//   RESET_PC    PC value loaded on reset
//   TIMEOUT     WAIT cycles without imem_ready before a fetch is abandoned (2..255)
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   IL                      instruction-load request (sampled only while idle)
//   pc_update, pc_sel       apply next-PC choice: 00 +4, 01 +offset*4, 10 reg_target, 11 hold
//   offset, reg_target      signed word offset / register branch target
//   imem_req, imem_addr     memory read request and byte address
//   imem_rdata, imem_ready  memory response word and strobe
//   I, I_valid              instruction register and its one-cycle "new" pulse
//   pc, pc_plus4            current PC and its combinational link value
//   busy                    fetch outstanding
//   fetch_fault             one-cycle pulse when a fetch times out
//   align_fault             one-cycle pulse when a register target was misaligned
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        IL,
  input  logic        pc_update,
  input  logic [1:0]  pc_sel,
  input  logic [63:0] offset,
  input  logic [63:0] reg_target,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] I,
  output logic        I_valid,
  output logic [63:0] pc,
  output logic [63:0] pc_plus4,
  output logic        busy,
  output logic        fetch_fault,
  output logic        align_fault
);

  typedef enum logic {IDLE, WAIT} state_t;

  // The counter holds the number of WAIT cycles already spent without ready,
  // so the cycle in which it equals TIMEOUT-1 is the last one we will wait.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [7:0]  wait_cnt;
  logic [63:0] addr_q;
  logic [63:0] pc_q;
  logic [63:0] pc_next;
  logic [63:0] offset_bytes;
  logic        align_hit;

  assign offset_bytes = offset << 2;
  assign pc           = pc_q;
  assign pc_plus4     = pc_q + 64'd4;
  assign busy         = (state_q == WAIT);
  assign imem_req     = (state_q == WAIT);
  assign imem_addr    = (state_q == WAIT) ? addr_q : pc_q;

  // Next-PC selection. Register targets are word-aligned by clearing the low
  // two bits; a non-zero low pair is flagged so the core can trap on it.
  always_comb begin
    pc_next   = pc_q;
    align_hit = 1'b0;
    if (pc_update) begin
      case (pc_sel)
        2'b00: pc_next = pc_plus4;
        2'b01: pc_next = pc_q + offset_bytes;
        2'b10: begin
          pc_next   = {reg_target[63:2], 2'b00};
          align_hit = (reg_target[1:0] != 2'b00);
        end
        default: pc_next = pc_q;
      endcase
    end
  end

  // Fetch controller and PC register. The PC may move while a fetch is in
  // flight; the request keeps using the address captured when it started.
  // Completion is checked before the timeout so a ready in the final allowed
  // cycle still loads the instruction.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_cnt    <= 8'd0;
      addr_q      <= RESET_PC;
      pc_q        <= RESET_PC;
      I           <= 32'h0;
      I_valid     <= 1'b0;
      fetch_fault <= 1'b0;
      align_fault <= 1'b0;
    end else begin
      I_valid     <= 1'b0;
      fetch_fault <= 1'b0;
      align_fault <= align_hit;
      pc_q        <= pc_next;
      case (state_q)
        IDLE: begin
          if (IL) begin
            state_q  <= WAIT;
            addr_q   <= pc_q;
            wait_cnt <= 8'd0;
          end
        end
        WAIT: begin
          if (imem_ready) begin
            I       <= imem_rdata;
            I_valid <= 1'b1;
            state_q <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            fetch_fault <= 1'b1;
            state_q     <= IDLE;
            wait_cnt    <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed and randomized bench for fetch_unit, compared each
// cycle against a behavioural model of the fetch/PC rules.
module tb_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h0000_0000_0000_1000;
  localparam int          TMO    = 16;

  logic        clock;
  logic        reset;
  logic        IL;
  logic        pc_update;
  logic [1:0]  pc_sel;
  logic [63:0] offset;
  logic [63:0] reg_target;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] I;
  logic        I_valid;
  logic [63:0] pc;
  logic [63:0] pc_plus4;
  logic        busy;
  logic        fetch_fault;
  logic        align_fault;

  int tests;
  int failures;
  int busyCount;

  // Behavioural model: outstanding-request flag, its captured address and age.
  logic [63:0] mPc;
  logic [31:0] mI;
  logic        mPending;
  logic [63:0] mAddr;
  int          mAge;
  logic        mValid;
  logic        mFetchFault;
  logic        mAlignFault;

  fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .IL(IL), .pc_update(pc_update), .pc_sel(pc_sel),
    .offset(offset), .reg_target(reg_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .I(I), .I_valid(I_valid), .pc(pc),
    .pc_plus4(pc_plus4), .busy(busy), .fetch_fault(fetch_fault), .align_fault(align_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelStep();
    logic [63:0] nextPc;
    if (reset) begin
      mPc = RST_PC; mI = 32'h0; mPending = 1'b0; mAge = 0;
      mValid = 1'b0; mFetchFault = 1'b0; mAlignFault = 1'b0;
    end else begin
      mValid = 1'b0; mFetchFault = 1'b0; mAlignFault = 1'b0;
      if (mPending) begin
        mAge = mAge + 1;
        if (imem_ready) begin
          mI = imem_rdata; mValid = 1'b1; mPending = 1'b0;
        end else if (mAge >= TMO) begin
          mFetchFault = 1'b1; mPending = 1'b0;
        end
      end else if (IL) begin
        mPending = 1'b1; mAddr = mPc; mAge = 0;
      end
      nextPc = mPc;
      if (pc_update) begin
        if (pc_sel == 2'd0) nextPc = mPc + 64'd4;
        else if (pc_sel == 2'd1) nextPc = mPc + offset * 64'd4;
        else if (pc_sel == 2'd2) begin
          nextPc = reg_target & ~64'd3;
          mAlignFault = (reg_target % 64'd4) != 64'd0;
        end
      end
      mPc = nextPc;
    end
  endtask

  task automatic checkOutput();
    checkValue("pc", pc, mPc);
    checkValue("pc_plus4", pc_plus4, mPc + 64'd4);
    checkValue("I", {32'h0, I}, {32'h0, mI});
    checkValue("I_valid", {63'h0, I_valid}, {63'h0, mValid});
    checkValue("busy", {63'h0, busy}, {63'h0, mPending});
    checkValue("imem_req", {63'h0, imem_req}, {63'h0, mPending});
    checkValue("imem_addr", imem_addr, mPending ? mAddr : mPc);
    checkValue("fetch_fault", {63'h0, fetch_fault}, {63'h0, mFetchFault});
    checkValue("align_fault", {63'h0, align_fault}, {63'h0, mAlignFault});
  endtask

  task automatic applyStimulus(input logic rst, input logic il, input logic upd, input logic [1:0] sel,
                               input logic [63:0] off, input logic [63:0] tgt,
                               input logic rdy, input logic [31:0] rdata);
    reset = rst; IL = il; pc_update = upd; pc_sel = sel; offset = off;
    reg_target = tgt; imem_ready = rdy; imem_rdata = rdata;
    modelStep();
    @(posedge clock);
    #1;
    checkOutput();
    if (busy) busyCount++;
  endtask

  initial begin
    tests = 0; failures = 0; busyCount = 0;
    mPc = 64'h0; mI = 32'h0; mPending = 1'b0; mAddr = 64'h0; mAge = 0;
    mValid = 1'b0; mFetchFault = 1'b0; mAlignFault = 1'b0;
    reset = 1'b1; IL = 1'b0; pc_update = 1'b0; pc_sel = 2'd0; offset = 64'h0;
    reg_target = 64'h0; imem_ready = 1'b0; imem_rdata = 32'h0;

    // Reset state.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0, 1, 32'hDEAD_BEEF);
    checkValue("reset_pc", pc, RST_PC);
    checkValue("reset_I", {32'h0, I}, 64'h0);
    checkValue("reset_req", {63'h0, imem_req}, 64'h0);

    // Fetch with three empty wait cycles, ready on the fourth.
    busyCount = 0;
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkValue("fetch_addr", imem_addr, RST_PC);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h1111_1111);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 32'h8B02_0020);
    checkValue("fetch_I", {32'h0, I}, 64'h8B02_0020);
    checkValue("fetch_valid", {63'h0, I_valid}, 64'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h2222_2222);
    checkValue("valid_pulse", {63'h0, I_valid}, 64'h0);
    checkValue("busy_cycles", busyCount, 64'd4);

    // Offset branch backward and silent wrap of PC+4.
    applyStimulus(0, 0, 1, 2, 0, 64'h100, 0, 0);
    applyStimulus(0, 0, 1, 1, -64'sd2, 0, 0, 0);
    checkValue("pc_offset", pc, 64'hF8);
    applyStimulus(0, 0, 1, 2, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    checkValue("pc_wrap", pc, 64'h0);
    applyStimulus(0, 0, 1, 3, 64'h5, 64'h40, 0, 0);
    checkValue("pc_hold", pc, 64'h0);

    // Misaligned register target.
    applyStimulus(0, 0, 1, 2, 0, 64'h203, 0, 0);
    checkValue("pc_align", pc, 64'h200);
    checkValue("align_pulse", {63'h0, align_fault}, 64'h1);
    applyStimulus(0, 0, 0, 2, 0, 64'h203, 0, 0);
    checkValue("align_clear", {63'h0, align_fault}, 64'h0);

    // Timeout: sixteen empty wait cycles abort; ready on the sixteenth completes.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 15; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkValue("tmo_still_busy", {63'h0, busy}, 64'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkValue("tmo_fault", {63'h0, fetch_fault}, 64'h1);
    checkValue("tmo_I_kept", {32'h0, I}, 64'h8B02_0020);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h3333_3333);
    checkValue("tmo_fault_pulse", {63'h0, fetch_fault}, 64'h0);
    checkValue("tmo_idle_ready", {32'h0, I}, 64'h8B02_0020);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 15; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D);
    checkValue("tmo_last_load", {32'h0, I}, 64'hCAFE_F00D);
    checkValue("tmo_last_nofault", {63'h0, fetch_fault}, 64'h0);

    // PC moves during a fetch, then reset aborts it before a late ready.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    checkValue("inflight_addr", imem_addr, 64'h200);
    checkValue("inflight_pc", pc, 64'h204);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h7777_7777);
    checkValue("abort_pc", pc, RST_PC);
    checkValue("abort_I", {32'h0, I}, 64'h0);
    checkValue("abort_valid", {63'h0, I_valid}, 64'h0);

    // Randomized traffic; memory alternates between prompt and sluggish.
    for (int n = 0; n < 800; n++) begin
      logic slow;
      logic rdy;
      slow = ((n / 64) % 2) == 1;
      rdy  = slow ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                    {$urandom, $urandom}, {$urandom, $urandom}, rdy, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
